// File: rtl/lc4_muldiv_pkg.sv
// Shared decode constants and enums for the LC4 multi-cycle MUL/DIV/MOD sequencer.
package lc4_muldiv_pkg;

    localparam logic [3:0] OP_ARITH = 4'b0001;
    localparam logic [3:0] OP_SHIFT = 4'b1010;
    localparam logic [2:0] SUB_MUL  = 3'b001;
    localparam logic [2:0] SUB_DIV  = 3'b011;
    localparam logic [1:0] SUB_MOD  = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_MOD} op_t;

endpackage

// File: rtl/lc4_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
module lc4_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {i_rem, i_quo[WIDTH-1]};
        if (shifted >= {1'b0, i_dvs}) begin
            // Partial remainder stays below the divisor, so the difference fits in WIDTH bits.
            o_rem = shifted[WIDTH-1:0] - i_dvs;
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = shifted[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/lc4_muldiv_seq.sv
// Multi-cycle LC4 MUL/DIV/MOD sequencer for the execute stage.
// Define LC4_MULDIV_ITER_MUL_EN to iterate MUL through RUN; otherwise MUL completes at accept.
module lc4_muldiv_seq
    import lc4_muldiv_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_gwe,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [15:0]      i_insn,
    input  logic [WIDTH-1:0] i_r1data,
    input  logic [WIDTH-1:0] i_r2data,
    output logic             o_stall,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int NSTEPS = WIDTH / STEPS_PER_CYCLE;
    localparam int CW     = $clog2(NSTEPS + 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;

    logic             is_muldiv;
    op_t              dec_op;
    logic             unused_insn_bits;

    always_comb begin
        is_muldiv = 1'b0;
        dec_op    = OP_DIV;
        if (i_insn[15:12] == OP_ARITH && i_insn[5:3] == SUB_MUL) begin
            is_muldiv = 1'b1;
            dec_op    = OP_MUL;
        end else if (i_insn[15:12] == OP_ARITH && i_insn[5:3] == SUB_DIV) begin
            is_muldiv = 1'b1;
            dec_op    = OP_DIV;
        end else if (i_insn[15:12] == OP_SHIFT && i_insn[5:4] == SUB_MOD) begin
            is_muldiv = 1'b1;
            dec_op    = OP_MOD;
        end
    end

    assign unused_insn_bits = ^{i_insn[11:6], i_insn[2:0]};

    // Restoring divider chain: STEPS_PER_CYCLE steps resolved per clock.
    logic [STEPS_PER_CYCLE:0][WIDTH-1:0] rem_c;
    logic [STEPS_PER_CYCLE:0][WIDTH-1:0] quo_c;

    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;

    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_div
        lc4_div_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .i_rem(rem_c[g]),
            .i_quo(quo_c[g]),
            .i_dvs(dvs_q),
            .o_rem(rem_c[g+1]),
            .o_quo(quo_c[g+1])
        );
    end

`ifdef LC4_MULDIV_ITER_MUL_EN
    // Shift-add multiply reuses rem_q as accumulator, quo_q as multiplier, dvs_q as multiplicand.
    logic [WIDTH-1:0] acc_c, mcd_c, mlr_c;

    always_comb begin
        acc_c = rem_q;
        mcd_c = dvs_q;
        mlr_c = quo_q;
        for (int unsigned i = 0; i < STEPS_PER_CYCLE; i++) begin
            if (mlr_c[0]) begin
                acc_c = acc_c + mcd_c;
            end
            mcd_c = mcd_c << 1;
            mlr_c = mlr_c >> 1;
        end
    end
`else
    logic [WIDTH-1:0] prod;

    assign prod = i_r1data * i_r2data;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        done_d  = 1'b0;
        if (!i_gwe) begin
            done_d = done_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start && is_muldiv && !i_flush) begin
                        op_d  = dec_op;
                        cnt_d = '0;
                        rem_d = '0;
                        quo_d = i_r1data;
                        dvs_d = i_r2data;
                        if (dec_op != OP_MUL && i_r2data == '0) begin
                            state_d = DONE;
                            res_d   = '0;
                            done_d  = 1'b1;
`ifndef LC4_MULDIV_ITER_MUL_EN
                        end else if (dec_op == OP_MUL) begin
                            state_d = DONE;
                            res_d   = prod;
                            done_d  = 1'b1;
`endif
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (i_flush) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
`ifdef LC4_MULDIV_ITER_MUL_EN
                        if (op_q == OP_MUL) begin
                            rem_d = acc_c;
                            quo_d = mlr_c;
                            dvs_d = mcd_c;
                        end else begin
                            rem_d = rem_c[STEPS_PER_CYCLE];
                            quo_d = quo_c[STEPS_PER_CYCLE];
                        end
`else
                        rem_d = rem_c[STEPS_PER_CYCLE];
                        quo_d = quo_c[STEPS_PER_CYCLE];
`endif
                        if (cnt_q == CW'(NSTEPS - 1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            case (op_q)
                                OP_MOD:  res_d = rem_c[STEPS_PER_CYCLE];
`ifdef LC4_MULDIV_ITER_MUL_EN
                                OP_MUL:  res_d = acc_c;
`endif
                                default: res_d = quo_c[STEPS_PER_CYCLE];
                            endcase
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_DIV;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign o_stall  = (state_q == RUN) ||
                      (state_q == IDLE && i_gwe && i_start && is_muldiv && !i_flush);
    assign o_done   = done_q;
    assign o_result = res_q;

endmodule

// File: tb/tb_lc4_muldiv_seq.sv
// Self-checking bench for lc4_muldiv_seq: directed cases plus random ops against an arithmetic model.
module tb_lc4_muldiv_seq;

`ifdef LC4_MULDIV_ITER_MUL_EN
    localparam int MUL_LAT = 17;
`else
    localparam int MUL_LAT = 1;
`endif
    localparam int DIV_LAT = 17;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_gwe;
    logic        i_start;
    logic        i_flush;
    logic [15:0] i_insn;
    logic [15:0] i_r1data;
    logic [15:0] i_r2data;
    logic        o_stall;
    logic        o_done;
    logic [15:0] o_result;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_res = 16'h0000;

    always #5 clk = ~clk;

    lc4_muldiv_seq #(
        .WIDTH(16),
        .STEPS_PER_CYCLE(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_gwe   (i_gwe),
        .i_start (i_start),
        .i_flush (i_flush),
        .i_insn  (i_insn),
        .i_r1data(i_r1data),
        .i_r2data(i_r2data),
        .o_stall (o_stall),
        .o_done  (o_done),
        .o_result(o_result)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input int kind, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        case (kind)
            0:       return 16'((ua * ub) % 65536);
            1:       return (ub == 0) ? 16'h0000 : 16'(ua / ub);
            default: return (ub == 0) ? 16'h0000 : 16'(ua % ub);
        endcase
    endfunction

    // Starts one op in the current cycle (cycle 0) and checks every cycle through the done pulse.
    task automatic do_op(input string tag, input logic [15:0] insn, input logic [15:0] a,
                         input logic [15:0] b, input int lat, input logic [15:0] exp_res,
                         input int gwe_lo_from, input int gwe_lo_to);
        i_insn   = insn;
        i_r1data = a;
        i_r2data = b;
        i_start  = 1'b1;
        i_gwe    = 1'b1;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check({tag, "_stall"}, {15'b0, o_stall}, {15'b0, (k < lat)});
            check({tag, "_done"}, {15'b0, o_done}, {15'b0, (k == lat)});
            if (k == lat) begin
                check({tag, "_result"}, o_result, exp_res);
                last_res = exp_res;
            end else begin
                check({tag, "_hold"}, o_result, last_res);
            end
            @(posedge clk);
            #1;
            i_start  = (k + 1 <= lat) ? 1'($urandom) : 1'b0;
            i_r1data = 16'($urandom);
            i_r2data = 16'($urandom);
            i_gwe    = !(k + 1 >= gwe_lo_from && k + 1 <= gwe_lo_to);
        end
        i_start = 1'b0;
        i_gwe   = 1'b1;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({tag, "_stall"}, {15'b0, o_stall}, 16'h0000);
            check({tag, "_done"}, {15'b0, o_done}, 16'h0000);
            check({tag, "_result"}, o_result, last_res);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b, insn;
        int          kind, lat;

        rst_n = 1'b0; i_gwe = 1'b1; i_start = 1'b0; i_flush = 1'b0;
        i_insn = 16'h0000; i_r1data = 16'h0000; i_r2data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_stall", {15'b0, o_stall}, 16'h0000);
        check("reset_done", {15'b0, o_done}, 16'h0000);
        check("reset_result", o_result, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_op("div_100_7", 16'h10DA, 16'd100, 16'd7, DIV_LAT, 16'd14, -1, -1);
        do_op("mod_100_7", 16'hA032, 16'd100, 16'd7, DIV_LAT, 16'd2, -1, -1);
        do_op("div_ffff_1", 16'h10DA, 16'hFFFF, 16'd1, DIV_LAT, 16'hFFFF, -1, -1);
        do_op("div_5_0", 16'h10DA, 16'd5, 16'd0, 1, 16'd0, -1, -1);
        do_op("mul_300", 16'h100A, 16'd300, 16'd300, MUL_LAT, 16'h5F90, -1, -1);
        do_op("mod_5_0", 16'hA032, 16'd5, 16'd0, 1, 16'd0, -1, -1);
        do_op("div_7_100", 16'h10DA, 16'd7, 16'd100, DIV_LAT, 16'd0, -1, -1);
        idle_check("post_ops", 2);

        // Flush at cycle 5 of a DIV: no done pulse, result keeps its prior value.
        do_op("mul_seed", 16'h100A, 16'd123, 16'd45, MUL_LAT, 16'd5535, -1, -1);
        i_insn = 16'h10DA; i_r1data = 16'd1000; i_r2data = 16'd3; i_start = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check("flush_run_stall", {15'b0, o_stall}, 16'h0001);
            check("flush_run_done", {15'b0, o_done}, 16'h0000);
            @(posedge clk);
            #1;
            i_start = 1'b0;
            i_flush = (k == 4);
        end
        i_flush = 1'b0;
        idle_check("after_flush", 20);

        i_insn = 16'h10DA; i_r1data = 16'd50; i_r2data = 16'd5; i_start = 1'b1; i_flush = 1'b1;
        idle_check("start_flush", 1);
        i_start = 1'b0; i_flush = 1'b0;
        idle_check("start_flush_after", 5);

        // Reset asserted in cycle 8 of a DIV clears everything.
        i_insn = 16'h10DA; i_r1data = 16'd999; i_r2data = 16'd9; i_start = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check("rst_run_stall", {15'b0, o_stall}, 16'h0001);
            @(posedge clk);
            #1;
            i_start = 1'b0;
            rst_n   = !(k == 7);
        end
        rst_n = 1'b1;
        last_res = 16'h0000;
        idle_check("after_rst", 4);

        do_op("div_gwe", 16'h10DA, 16'd1234, 16'd10, DIV_LAT + 4, 16'd123, 3, 6);

        i_insn = 16'h1000; i_r1data = 16'd3; i_r2data = 16'd4; i_start = 1'b1;
        idle_check("add_start", 20);
        i_insn = 16'hA020;
        idle_check("shift_start", 4);
        i_start = 1'b0;

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            a    = 16'($urandom);
            b    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            case (kind)
                0:       insn = {4'b0001, 6'($urandom), 3'b001, 3'($urandom)};
                1:       insn = {4'b0001, 6'($urandom), 3'b011, 3'($urandom)};
                default: insn = {4'b1010, 6'($urandom), 2'b11, 4'($urandom)};
            endcase
            if (kind == 0)      lat = MUL_LAT;
            else if (b == 0)    lat = 1;
            else                lat = DIV_LAT;
            do_op("rand", insn, a, b, lat, model(kind, a, b), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
